totp_host_loader: RTL and testbench
===================================

Name: totp_host_loader

Overview:
- Host-side transmitter for the TOTP core's serial load interface: drives `data`, `key_en` and `msg_en`, and waits for the core's `ready` output.
- Holds a byte-addressable key RAM and a free-running TOTP time-step counter.
- On a start request, snapshots the step counter and serializes the key and then the 64-bit counter into the core.
- Sits between a host/config interface and the core's `ui_in[2:0]` / `uo_out[7]`.

Parameters:
- KEY_BYTES, 20, key RAM depth in bytes (max 31).
- CLK_DIV, 1000, clock cycles per one-second tick (≥2).
- STEP_SECS, 30, seconds per TOTP step (≥1).
- WAIT_MAX, 65535, cycles to wait for `ready_in` before timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- key_wr  in  1  write strobe for key RAM
- key_addr  in  5  key byte address (writes with addr ≥ KEY_BYTES ignored)
- key_wdata  in  8  key byte
- key_len  in  5  valid key length in bytes, sampled at start
- epoch_set  in  1  load step counter
- epoch_in  in  64  step value loaded on epoch_set
- start  in  1  one-cycle load request
- auto_en  in  1  start automatically on each step rollover
- ready_in  in  1  core `ready` output
- data  out  1  serial bit to core
- key_en  out  1  key bit valid
- msg_en  out  1  message bit valid
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse: core reported ready
- timeout  out  1  one-cycle pulse: WAIT_MAX expired
- step  out  64  current step counter

Behaviour:
- Single clock. All state updates on posedge clk.
- Reset (synchronous, active-high):
  - data/key_en/msg_en/busy/done/timeout = 0.
  - step = 0; prescaler = 0; seconds = 0.
  - FSM = IDLE. Key RAM contents are not reset.
- Timebase:
  - Prescaler counts 0..CLK_DIV-1; the cycle at CLK_DIV-1 is a second tick.
  - seconds counts 0..STEP_SECS-1, advancing on each tick.
  - A tick with seconds = STEP_SECS-1 is a rollover: step increments, wrapping 2^64-1→0.
  - epoch_set: step ← epoch_in, prescaler and seconds cleared, no rollover that cycle. epoch_set has priority over increment.
- Start request = start OR (auto_en AND rollover). It is accepted only in IDLE and is ignored otherwise (no queuing).
- On acceptance:
  - msg_shadow ← step value after this cycle's update.
  - len ← min(key_len, KEY_BYTES).
  - busy = 1 from the next cycle.
- FSM states:
  - IDLE: waiting for a start request.
  - KEY:
    - One bit per cycle: bytes 0..len-1 in order, each byte MSB first, key_en = 1, data = bit.
    - After 8·len cycles → GAP.
    - If len = 0, go directly to GAP.
  - GAP: one cycle, all outputs low. → MSG.
  - MSG:
    - 64 cycles, msg_shadow MSB first, msg_en = 1.
    - → WAIT with wait counter = 0.
  - WAIT:
    - Outputs low.
    - If ready_in = 1: done pulse, → IDLE.
    - Else if wait counter = WAIT_MAX-1: timeout pulse, → IDLE.
    - Else counter++.
    - ready_in is checked first in the cycle WAIT is entered.
- key_en and msg_en are never both 1. data = 0 whenever both enables are 0.
- busy = 1 in KEY/GAP/MSG/WAIT. done and timeout each last 1 cycle and are asserted in the cycle after the decision, together with busy falling.
- key_wr during KEY:
  - Permitted; a write takes effect next cycle.
  - A byte already being shifted is taken from a per-byte shift register loaded at byte start, so it is unaffected.
- Rollover or epoch_set during transfer updates `step` but not msg_shadow.
- rst mid-transfer aborts immediately. Outputs are low the next cycle. No done/timeout pulse.

Test Plan:
- Write key bytes 0x12,0x34, key_len=2, epoch_set with 0x0000_0000_0000_00A5, start → over 16 cycles key_en=1 and data=0001_0010_0011_0100; 1 gap cycle; 64 cycles msg_en=1 with the final 8 data bits = 1010_0101; ready_in=1 two cycles later → done pulse, busy falls.
- CLK_DIV=4, STEP_SECS=3, auto_en=1, from reset → step=1 after 12 cycles and a transfer starts automatically carrying message value 1; step=2 at cycle 24.
- key_len=0 → no key_en cycles; GAP follows start immediately, then 64 msg_en cycles.
- key_len=31 with KEY_BYTES=20 → exactly 160 key_en cycles.
- WAIT_MAX=10, ready_in held 0 → timeout pulse exactly 10 cycles after WAIT is entered, no done pulse. start while busy → ignored.
- Assert rst during MSG cycle 30 → next cycle all outputs 0, step=0; a fresh start then performs a full, clean transfer.

Source files
------------

// File: rtl/totp_host_loader.sv
// Host-side loader for the TOTP core serial interface.
// Keeps a key RAM and a free-running time-step counter. On a start request it
// snapshots the step and shifts the key, then the 64-bit step, into the core.
// After that it waits for the core's ready flag, or gives up after WAIT_MAX cycles.
module totp_host_loader #(
    parameter int unsigned KEY_BYTES = 20,
    parameter int unsigned CLK_DIV   = 1000,
    parameter int unsigned STEP_SECS = 30,
    parameter int unsigned WAIT_MAX  = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_wr,
    input  logic [4:0]  key_addr,
    input  logic [7:0]  key_wdata,
    input  logic [4:0]  key_len,
    input  logic        epoch_set,
    input  logic [63:0] epoch_in,
    input  logic        start,
    input  logic        auto_en,
    input  logic        ready_in,
    output logic        data,
    output logic        key_en,
    output logic        msg_en,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [63:0] step
);

    localparam int unsigned PreW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned SecW  = $clog2(STEP_SECS + 1);
    localparam int unsigned WaitW = $clog2(WAIT_MAX + 1);

    localparam logic [PreW-1:0]  PreLast   = PreW'(CLK_DIV - 1);
    localparam logic [SecW-1:0]  SecLast   = SecW'(STEP_SECS - 1);
    localparam logic [WaitW-1:0] WaitLast  = WaitW'(WAIT_MAX - 1);
    localparam logic [4:0]       KeyBytesW = 5'(KEY_BYTES);

    typedef enum logic [2:0] {StIdle, StKey, StGap, StMsg, StWait} state_e;

    state_e             state_q, state_d;
    logic [PreW-1:0]    pre_q, pre_d;
    logic [SecW-1:0]    sec_q, sec_d;
    logic [63:0]        step_q, step_d;
    logic [63:0]        msg_q, msg_d;      // step snapshot, shifted out MSB first
    logic [4:0]         len_q, len_d;
    logic [4:0]         byte_q, byte_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;  // remaining bits of the byte on the wire
    logic [5:0]         mcnt_q, mcnt_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic               data_q, data_d;
    logic               key_en_q, key_en_d;
    logic               msg_en_q, msg_en_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;

    logic [7:0]         key_ram_q [KEY_BYTES];

    logic               tick;
    logic               roll;
    logic               start_req;
    logic [4:0]         len_sel;
    logic [4:0]         next_byte;
    logic [7:0]         first_byte;
    logic [7:0]         nb_byte;

    // Key RAM write port; contents survive reset, out-of-range addresses dropped.
    always_ff @(posedge clk) begin
        if (key_wr && (key_addr < KeyBytesW)) begin
            key_ram_q[key_addr] <= key_wdata;
        end
    end

    // Next-state logic: timebase, step counter and the serializer FSM.
    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        sec_d     = sec_q;
        step_d    = step_q;
        msg_d     = msg_q;
        len_d     = len_q;
        byte_d    = byte_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        mcnt_d    = mcnt_q;
        wait_d    = wait_q;
        data_d    = data_q;
        key_en_d  = key_en_q;
        msg_en_d  = msg_en_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;

        tick       = (pre_q == PreLast);
        roll       = tick && (sec_q == SecLast) && !epoch_set;
        start_req  = start | (auto_en & roll);
        len_sel    = (key_len > KeyBytesW) ? KeyBytesW : key_len;
        next_byte  = byte_q + 5'd1;
        first_byte = key_ram_q[5'd0];
        nb_byte    = key_ram_q[next_byte];

        // epoch_set wins over the normal count and restarts the second phase
        if (epoch_set) begin
            step_d = epoch_in;
            pre_d  = '0;
            sec_d  = '0;
        end else begin
            pre_d = tick ? '0 : pre_q + PreW'(1);
            if (tick) begin
                sec_d = (sec_q == SecLast) ? '0 : sec_q + SecW'(1);
            end
            if (roll) begin
                step_d = step_q + 64'd1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start_req) begin
                    msg_d  = step_d;
                    len_d  = len_sel;
                    byte_d = '0;
                    bit_d  = '0;
                    if (len_sel == 5'd0) begin
                        state_d = StGap;
                    end else begin
                        state_d  = StKey;
                        key_en_d = 1'b1;
                        data_d   = first_byte[7];
                        shift_d  = {first_byte[6:0], 1'b0};
                    end
                end
            end
            StKey: begin
                if (bit_q == 3'd7) begin
                    if (byte_q == len_q - 5'd1) begin
                        state_d  = StGap;
                        key_en_d = 1'b0;
                        data_d   = 1'b0;
                    end else begin
                        // RAM is read only here, so later writes never touch a byte in flight
                        byte_d  = next_byte;
                        bit_d   = '0;
                        data_d  = nb_byte[7];
                        shift_d = {nb_byte[6:0], 1'b0};
                    end
                end else begin
                    bit_d   = bit_q + 3'd1;
                    data_d  = shift_q[7];
                    shift_d = {shift_q[6:0], 1'b0};
                end
            end
            StGap: begin
                state_d  = StMsg;
                msg_en_d = 1'b1;
                data_d   = msg_q[63];
                msg_d    = {msg_q[62:0], 1'b0};
                mcnt_d   = '0;
            end
            StMsg: begin
                if (mcnt_q == 6'd63) begin
                    state_d  = StWait;
                    msg_en_d = 1'b0;
                    data_d   = 1'b0;
                    wait_d   = '0;
                end else begin
                    mcnt_d = mcnt_q + 6'd1;
                    data_d = msg_q[63];
                    msg_d  = {msg_q[62:0], 1'b0};
                end
            end
            StWait: begin
                if (ready_in) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (wait_q == WaitLast) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            default: begin
                state_d  = StIdle;
                key_en_d = 1'b0;
                msg_en_d = 1'b0;
                data_d   = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset; a reset aborts any transfer silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            pre_q     <= '0;
            sec_q     <= '0;
            step_q    <= '0;
            msg_q     <= '0;
            len_q     <= '0;
            byte_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            mcnt_q    <= '0;
            wait_q    <= '0;
            data_q    <= 1'b0;
            key_en_q  <= 1'b0;
            msg_en_q  <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            sec_q     <= sec_d;
            step_q    <= step_d;
            msg_q     <= msg_d;
            len_q     <= len_d;
            byte_q    <= byte_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            mcnt_q    <= mcnt_d;
            wait_q    <= wait_d;
            data_q    <= data_d;
            key_en_q  <= key_en_d;
            msg_en_q  <= msg_en_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    assign data    = data_q;
    assign key_en  = key_en_q;
    assign msg_en  = msg_en_q;
    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign timeout = timeout_q;
    assign step    = step_q;

endmodule

// File: tb/tb_totp_host_loader.sv
// Directed bench for totp_host_loader with a bit-level scoreboard of the serial stream.
module tb_totp_host_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_wr;
    logic [4:0]  key_addr;
    logic [7:0]  key_wdata;
    logic [4:0]  key_len;
    logic        epoch_set;
    logic [63:0] epoch_in;
    logic        start;
    logic        auto_en;
    logic        ready_in;
    logic        data;
    logic        key_en;
    logic        msg_en;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [63:0] step;

    typedef struct packed {
        logic is_key;
        logic b;
    } bit_t;

    bit_t        exp_q[$];
    logic [7:0]  ram_m [20];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          step_at = -1;
    logic [63:0] step_val = '0;

    totp_host_loader #(
        .KEY_BYTES (20),
        .CLK_DIV   (4),
        .STEP_SECS (3),
        .WAIT_MAX  (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_wr    (key_wr),
        .key_addr  (key_addr),
        .key_wdata (key_wdata),
        .key_len   (key_len),
        .epoch_set (epoch_set),
        .epoch_in  (epoch_in),
        .start     (start),
        .auto_en   (auto_en),
        .ready_in  (ready_in),
        .data      (data),
        .key_en    (key_en),
        .msg_en    (msg_en),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .step      (step)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: land on the falling edge, where outputs are stable.
    task automatic tk();
        @(negedge clk);
        cyc++;
        if (step_at >= 0 && cyc == step_at - 1) chk("step_before_roll", step, step_val - 64'd1);
        if (step_at >= 0 && cyc == step_at) chk("step_at_roll", step, step_val);
    endtask

    task automatic wr_key(input int a, input logic [7:0] v);
        key_wr    = 1'b1;
        key_addr  = 5'(a);
        key_wdata = v;
        tk();
        key_wr = 1'b0;
        if (a < 20) ram_m[a] = v;
    endtask

    task automatic push_exp(input int nbytes, input logic [63:0] msg);
        bit_t e;
        logic [7:0] kb;
        for (int b = 0; b < nbytes; b++) begin
            kb = ram_m[b];
            for (int i = 7; i >= 0; i--) begin
                e.is_key = 1'b1;
                e.b      = kb[i];
                exp_q.push_back(e);
            end
        end
        for (int i = 63; i >= 0; i--) begin
            e.is_key = 1'b0;
            e.b      = msg[i];
            exp_q.push_back(e);
        end
    endtask

    // Called on the first cycle after acceptance; walks key, gap, message and wait phases.
    task automatic run_xfer(input int nkey, input int ready_after, input bit mid_wr);
        bit_t e;
        chk("sb_depth", exp_q.size(), nkey + 64);
        for (int i = 0; i < nkey; i++) begin
            chk("key_busy", busy, 1'b1);
            chk("key_en", {key_en, msg_en}, 2'b10);
            e = exp_q.pop_front();
            chk("key_kind", e.is_key, 1'b1);
            chk("key_bit", data, e.b);
            key_wr = 1'b0;
            if (mid_wr && i == 2) begin
                key_wr = 1'b1; key_addr = 5'd0; key_wdata = 8'hEE;
            end
            if (mid_wr && i == 3) begin
                key_wr = 1'b1; key_addr = 5'd19; key_wdata = ram_m[19];
            end
            tk();
        end
        key_wr = 1'b0;
        if (mid_wr) ram_m[0] = 8'hEE;
        chk("gap_outs", {key_en, msg_en, data}, 3'b000);
        chk("gap_busy", busy, 1'b1);
        tk();
        for (int i = 0; i < 64; i++) begin
            chk("msg_en", {key_en, msg_en, busy}, 3'b011);
            e = exp_q.pop_front();
            chk("msg_kind", e.is_key, 1'b0);
            chk("msg_bit", data, e.b);
            tk();
        end
        chk("sb_drained", exp_q.size(), 0);
        chk("wait_outs", {key_en, msg_en, data}, 3'b000);
        if (ready_after >= 0) begin
            for (int i = 0; i < ready_after; i++) begin
                chk("wait_hold", {busy, done, timeout}, 3'b100);
                tk();
            end
            ready_in = 1'b1;
            tk();
            ready_in = 1'b0;
            chk("done_pulse", {busy, done, timeout}, 3'b010);
            tk();
            chk("done_end", {busy, done, timeout}, 3'b000);
        end else begin
            for (int i = 0; i < 10; i++) begin
                chk("wait_to_hold", {busy, done, timeout}, 3'b100);
                start = (i == 2);
                tk();
            end
            start = 1'b0;
            chk("timeout_pulse", {busy, done, timeout}, 3'b001);
            tk();
            chk("timeout_end", {busy, done, timeout}, 3'b000);
            tk();
            chk("start_ignored", busy, 1'b0);
        end
    endtask

    // Drives epoch_set and start together so the message value is known exactly.
    task automatic kick(input logic [4:0] len, input logic [63:0] val, input int nbytes);
        chk("idle_before_start", busy, 1'b0);
        key_len   = len;
        epoch_set = 1'b1;
        epoch_in  = val;
        start     = 1'b1;
        push_exp(nbytes, val);
        tk();
        epoch_set = 1'b0;
        start     = 1'b0;
        chk("epoch_load", step, val);
    endtask

    initial begin
        rst = 1'b1; key_wr = 1'b0; key_addr = '0; key_wdata = '0; key_len = '0;
        epoch_set = 1'b0; epoch_in = '0; start = 1'b0; auto_en = 1'b0; ready_in = 1'b0;
        tk(); tk(); tk();
        chk("rst_outs", {data, key_en, msg_en, busy, done, timeout}, 6'b0);
        chk("rst_step", step, 64'd0);

        // Auto start on the first rollover from reset.
        auto_en = 1'b1;
        key_len = 5'd0;
        rst = 1'b0;
        cyc = 0;
        while (cyc < 11) tk();
        chk("auto_pre_step", step, 64'd0);
        chk("auto_pre_busy", busy, 1'b0);
        push_exp(0, 64'd1);
        tk();
        auto_en = 1'b0;
        chk("auto_step1", step, 64'd1);
        step_at  = 24;
        step_val = 64'd2;
        run_xfer(0, 1, 1'b0);
        step_at = -1;

        // Two key bytes, epoch 0xA5, ready two cycles into WAIT.
        wr_key(0, 8'h12);
        wr_key(1, 8'h34);
        kick(5'd2, 64'h0000_0000_0000_00A5, 2);
        run_xfer(16, 2, 1'b0);

        // Empty key, core never answers: timeout with a start poked while waiting.
        kick(5'd0, 64'h8000_0000_0000_0001, 0);
        run_xfer(0, -1, 1'b0);

        // Oversized key_len clips to 20 bytes; key writes land during the transfer.
        for (int b = 0; b < 20; b++) wr_key(b, 8'(b * 37 + 5));
        wr_key(25, 8'hFF);
        ram_m[19] = 8'h5A;
        kick(5'd31, 64'hDEAD_BEEF_0123_4567, 20);
        run_xfer(160, 0, 1'b1);

        // Step counter wraps from all-ones to zero.
        epoch_set = 1'b1;
        epoch_in  = 64'hFFFF_FFFF_FFFF_FFFF;
        tk();
        epoch_set = 1'b0;
        for (int i = 0; i < 11; i++) tk();
        chk("wrap_pre", step, 64'hFFFF_FFFF_FFFF_FFFF);
        tk();
        chk("wrap_zero", step, 64'd0);
        chk("wrap_idle", busy, 1'b0);

        // Reset in message cycle 30, then a clean transfer.
        kick(5'd0, 64'h0F0F_0F0F_0F0F_0F0F, 0);
        tk();
        for (int i = 0; i < 30; i++) tk();
        chk("abort_in_msg", msg_en, 1'b1);
        rst = 1'b1;
        tk();
        chk("abort_outs", {data, key_en, msg_en, busy, done, timeout}, 6'b0);
        chk("abort_step", step, 64'd0);
        rst = 1'b0;
        exp_q.delete();
        tk();
        kick(5'd2, 64'h0123_4567_89AB_CDEF, 2);
        run_xfer(16, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
